// File: rtl/mdu.sv
// mdu: RISC-V M-extension multiply/divide unit.
//   Multiplies take one cycle in MUL. Divides use a restoring radix-2 divider,
//   one quotient bit per cycle (32 cycles for *W, XLEN otherwise). Divide-by-zero
//   and signed overflow skip straight to DONE.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   in_valid/in_ready - request handshake (in_ready only in IDLE)
//   funct3, word      - operation select, *W variant (ignored when XLEN=32)
//   a, b, tag_in      - operands and pass-through tag, captured at accept
//   kill              - flush: abort in-flight op, drop pending result
//   out_valid/out_ready, result, tag_out - response handshake, held in DONE
//   busy              - unit not idle
module mdu #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic             word,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);
  localparam int SH = XLEN - 32;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;

  function automatic logic [XLEN-1:0] sx32(input logic [XLEN-1:0] x);
    return XLEN'($signed(x << SH) >>> SH);
  endfunction

  function automatic logic [XLEN-1:0] zx32(input logic [XLEN-1:0] x);
    return (x << SH) >> SH;
  endfunction

  // ---- accept-side decode ----
  logic            wd, sa, sb, accept, div0, ovf, fast;
  logic [XLEN-1:0] ac, bc, amag, bmag, min_neg, fast_res;

  assign wd = (XLEN == 64) && word;
  // operand signedness: mul ops by funct3[1:0], div ops signed when funct3[0]=0
  assign sa = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign sb = funct3[2] ? ~funct3[0] : ~funct3[1];
  // *W operands are reduced to 32 bits and re-extended, so the full-width
  // datapath produces exact 32-bit results
  assign ac   = !wd ? a : (sa ? sx32(a) : zx32(a));
  assign bc   = !wd ? b : (sb ? sx32(b) : zx32(b));
  assign amag = (sa && ac[XLEN-1]) ? -ac : ac;
  assign bmag = (sb && bc[XLEN-1]) ? -bc : bc;

  assign min_neg = wd ? sx32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
  assign div0    = (bc == '0);
  assign ovf     = sa && (ac == min_neg) && (bc == '1);
  assign fast    = funct3[2] && (div0 || ovf);
  assign accept  = in_valid && (state == IDLE) && !kill;

  always_comb begin
    if (div0) fast_res = funct3[1] ? (wd ? sx32(a) : a) : '1;
    else      fast_res = funct3[1] ? '0 : ac;
  end

  // ---- captured operation ----
  logic [2:0]      fn_q;
  logic            wd_q, sa_q, sb_q, neg_q, neg_r;
  logic [XLEN-1:0] aq, bq, dq, dr, dd;
  logic [CW-1:0]   cnt;

  // ---- multiplier: sign/zero extend to 2*XLEN, low 2*XLEN bits are exact ----
  logic [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN-1:0]   mul_res;

  assign ma   = {{XLEN{sa_q & aq[XLEN-1]}}, aq};
  assign mb   = {{XLEN{sb_q & bq[XLEN-1]}}, bq};
  assign prod = ma * mb;

  always_comb begin
    if (fn_q[1:0] == 2'b00) mul_res = wd_q ? sx32(prod[XLEN-1:0]) : prod[XLEN-1:0];
    else                    mul_res = wd_q ? sx32(XLEN'(prod[63:32])) : prod[2*XLEN-1:XLEN];
  end

  // ---- restoring divider step: dq shifts dividend out / quotient in ----
  logic [XLEN:0]   shl, trial;
  logic            qbit;
  logic [XLEN-1:0] q_nx, r_nx, qf, rf, div_res;

  assign shl   = {dr, dq[XLEN-1]};
  assign trial = shl - {1'b0, dd};
  assign qbit  = ~trial[XLEN];
  assign q_nx  = {dq[XLEN-2:0], qbit};
  assign r_nx  = qbit ? trial[XLEN-1:0] : shl[XLEN-1:0];
  assign qf    = neg_q ? -q_nx : q_nx;
  assign rf    = neg_r ? -r_nx : r_nx;

  always_comb begin
    div_res = fn_q[1] ? rf : qf;
    if (wd_q) div_res = sx32(div_res);
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = fast ? DONE : (funct3[2] ? DIV : MUL);
      MUL:     state_nx = DONE;
      DIV:     if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (kill) state_nx = IDLE;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (reset) begin
      result  <= '0;
      tag_out <= '0;
    end else begin
      if (accept) begin
        fn_q    <= funct3;
        wd_q    <= wd;
        sa_q    <= sa;
        sb_q    <= sb;
        aq      <= ac;
        bq      <= bc;
        // left-align a 32-bit dividend so iteration starts at its bit 31
        dq      <= amag << (wd ? SH : 0);
        dr      <= '0;
        dd      <= bmag;
        neg_q   <= sa && (ac[XLEN-1] ^ bc[XLEN-1]);
        neg_r   <= sa && ac[XLEN-1];
        cnt     <= wd ? CW'(32) : CW'(XLEN);
        tag_out <= tag_in;
        if (fast) result <= fast_res;
      end
      if (state == MUL) result <= mul_res;
      if (state == DIV) begin
        dq  <= q_nx;
        dr  <= r_nx;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) result <= div_res;
      end
    end
  end
endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, word, kill, out_ready;
  logic [2:0]  funct3;
  logic [63:0] a, b;
  logic [4:0]  tag_in;
  logic        in_ready, out_valid, busy;
  logic [63:0] result;
  logic [4:0]  tag_out;

  mdu #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .word(word), .a(a), .b(b), .tag_in(tag_in), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .tag_out(tag_out), .busy(busy)
  );

  // 32-bit instance, driven sequentially at the end
  logic        in_valid_s, word_s, kill_s, out_ready_s;
  logic [2:0]  funct3_s;
  logic [31:0] a_s, b_s, result_s;
  logic [4:0]  tag_in_s, tag_out_s;
  logic        in_ready_s, out_valid_s, busy_s;

  mdu #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .funct3(funct3_s), .word(word_s), .a(a_s), .b(b_s), .tag_in(tag_in_s),
    .kill(kill_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .result(result_s), .tag_out(tag_out_s), .busy(busy_s)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, expv);
    end
  endtask

  // Reference: RISC-V M semantics from plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] fn, input logic w,
                                            input logic [63:0] x, input logic [63:0] y,
                                            input int xl);
    bit n32, sx, sy;
    logic [127:0] ex, ey, p;
    logic [63:0] r;
    int si, sj;
    int unsigned ui, uj;
    longint sl, sm;
    longint unsigned ul, um;
    n32 = w || (xl == 32);
    sx  = fn[2] ? !fn[0] : (fn[1:0] != 2'b11);
    sy  = fn[2] ? !fn[0] : !fn[1];
    if (!fn[2]) begin
      if (n32) begin
        ex = sx ? {{96{x[31]}}, x[31:0]} : {96'b0, x[31:0]};
        ey = sy ? {{96{y[31]}}, y[31:0]} : {96'b0, y[31:0]};
      end else begin
        ex = sx ? {{64{x[63]}}, x} : {64'b0, x};
        ey = sy ? {{64{y[63]}}, y} : {64'b0, y};
      end
      p = ex * ey;
      if (fn[1:0] == 2'b00) r = p[63:0];
      else                  r = n32 ? {32'b0, p[63:32]} : p[127:64];
    end else if (n32) begin
      si = x[31:0]; sj = y[31:0]; ui = x[31:0]; uj = y[31:0];
      if (uj == 0)                                                  r = fn[1] ? {32'b0, x[31:0]} : '1;
      else if (sx && x[31:0] == 32'h8000_0000 && y[31:0] == '1)    r = fn[1] ? 64'd0 : {32'b0, x[31:0]};
      else if (sx)                                                  r = fn[1] ? 64'(si % sj) : 64'(si / sj);
      else                                                          r = fn[1] ? 64'(ui % uj) : 64'(ui / uj);
    end else begin
      sl = x; sm = y; ul = x; um = y;
      if (y == 0)                                                   r = fn[1] ? x : '1;
      else if (sx && x == 64'h8000_0000_0000_0000 && y == '1)      r = fn[1] ? 64'd0 : x;
      else if (sx)                                                  r = fn[1] ? sl % sm : sl / sm;
      else                                                          r = fn[1] ? ul % um : ul / um;
    end
    return n32 ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'h0000_0000_FFFF_FFFF;
      6: return 64'hFFFF_FFFF_8000_0000;
      7: return v >> $urandom_range(0, 63);
      default: return v;
    endcase
  endfunction

  // Monitor: pops on every result handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset) chk("in_ready_vs_busy", 64'(in_ready), 64'(!busy));
      if (!reset && out_valid && out_ready && !kill) begin
        if (q.size() == 0) chk("unexpected_result", 64'(out_valid), 64'd0);
        else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("tag_out", 64'(tag_out), 64'(e.tag));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] fn, input logic w, input logic [63:0] x, input logic [63:0] y);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    if (!in_ready) chk("issue_timeout", 64'(in_ready), 64'd1);
    funct3 = fn; word = w; a = x; b = y; tag_in = 5'($urandom); in_valid = 1'b1;
    q.push_back('{ref_model(fn, w, x, y, 64), tag_in});
    @(posedge clk); #1;
    // later input changes must not affect the captured op
    in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; funct3 = 3'($urandom);
  endtask

  task automatic run_op(input string nm, input logic [2:0] fn, input logic w,
                        input logic [63:0] x, input logic [63:0] y,
                        input int lat, input logic [63:0] expv);
    int c = 0;
    issue(fn, w, x, y);
    do begin @(negedge clk); c++; end while (!out_valid && c < 200);
    chk({nm, "_latency"}, 64'(c), 64'(lat));
    chk(nm, result, expv);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_in_ready"},  64'(in_ready),  64'd1);
    chk({nm, "_busy"},      64'(busy),      64'd0);
    chk({nm, "_result"},    result,         64'd0);
    chk({nm, "_tag_out"},   64'(tag_out),   64'd0);
  endtask

  initial begin
    logic [63:0] hr, op, ev;
    logic [4:0]  ht;
    int c;
    reset = 1; in_valid = 0; word = 0; kill = 0; out_ready = 1; funct3 = 0;
    a = 0; b = 0; tag_in = 0;
    in_valid_s = 0; word_s = 0; kill_s = 0; out_ready_s = 1; funct3_s = 0;
    a_s = 0; b_s = 0; tag_in_s = 0;
    in_valid = 1; kill = 1;  // reset overrides both
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    in_valid = 0; kill = 0;
    @(negedge clk); reset = 0;

    // directed
    run_op("mulh_m1_m1",   3'b001, 0, '1, '1, 2, 64'd0);
    run_op("mulhu_m1_m1",  3'b011, 0, '1, '1, 2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu_m1_2",  3'b010, 0, '1, 64'd2, 2, '1);
    run_op("mulw_wrap",    3'b000, 1, 64'h1234_5678_7FFF_FFFF, 64'd2, 2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("div_m7_2",     3'b100, 0, -64'sd7, 64'd2, 65, -64'sd3);
    run_op("rem_m7_2",     3'b110, 0, -64'sd7, 64'd2, 65, '1);
    run_op("divuw_ff_1",   3'b101, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 33, '1);
    run_op("div_by_zero",  3'b100, 0, 64'd5, 64'd0, 1, '1);
    run_op("rem_by_zero",  3'b110, 0, 64'd5, 64'd0, 1, 64'd5);
    run_op("div_overflow", 3'b100, 0, 64'h8000_0000_0000_0000, '1, 1, 64'h8000_0000_0000_0000);
    run_op("rem_overflow", 3'b110, 0, 64'h8000_0000_0000_0000, '1, 1, 64'd0);
    run_op("remuw_zero",   3'b111, 1, 64'h0000_0000_8000_0001, 64'hABCD_0000_0000_0000, 1, 64'hFFFF_FFFF_8000_0001);

    // stall in DONE
    out_ready = 0;
    issue(3'b000, 0, 64'd12345, 64'd678);
    c = 0;
    while (!out_valid && c < 10) begin @(negedge clk); c++; end
    hr = result; ht = tag_out;
    chk("stall_result_value", hr, 64'd8369910);
    in_valid = 1; funct3 = 3'b001; a = 64'd9; b = 64'd9;
    repeat (10) begin
      @(negedge clk);
      chk("stall_result",    result,          hr);
      chk("stall_tag",       64'(tag_out),    64'(ht));
      chk("stall_in_ready",  64'(in_ready),   64'd0);
      chk("stall_out_valid", 64'(out_valid),  64'd1);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    chk("release_idle", 64'(in_ready), 64'd1);

    // kill mid-divide with a competing request
    issue(3'b100, 0, 64'd1000, 64'd7);
    repeat (19) @(negedge clk);
    kill = 1; in_valid = 1; funct3 = 3'b000; a = 64'd3; b = 64'd4;
    q.delete();
    @(posedge clk); #1;
    chk("kill_busy",      64'(busy),      64'd0);
    chk("kill_out_valid", 64'(out_valid), 64'd0);
    kill = 0; in_valid = 0;
    run_op("after_kill_div", 3'b100, 0, 64'd1000, 64'd7, 65, 64'd142);

    // reset mid-divide, and in DONE
    issue(3'b101, 0, {$urandom, $urandom}, 64'd3);
    repeat (10) @(negedge clk);
    reset = 1; q.delete();
    @(posedge clk); #1 chk_reset_vals("reset_mid_div");
    @(negedge clk); reset = 0;
    out_ready = 0;
    issue(3'b000, 0, 64'd5, 64'd6);
    repeat (3) @(negedge clk);
    reset = 1; q.delete();
    @(posedge clk); #1 chk_reset_vals("reset_in_done");
    @(negedge clk); reset = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    chk("no_stale_valid", 64'(out_valid), 64'd0);

    // random stream with random out_ready and kill
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      kill      = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      funct3    = 3'($urandom); word = 1'($urandom);
      a = rnd_op(); b = rnd_op(); tag_in = 5'($urandom);
      if (kill) q.delete();
      else if (in_valid && in_ready) q.push_back('{ref_model(funct3, word, a, b, 64), tag_in});
    end
    @(negedge clk);
    in_valid = 0; kill = 0; out_ready = 1;
    c = 0;
    while (busy && c < 100) begin @(negedge clk); c++; end
    @(negedge clk);
    chk("drain_idle", 64'(busy), 64'd0);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    // XLEN=32 instance: word must be ignored
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      op = rnd_op(); a_s = op[31:0];
      op = rnd_op(); b_s = op[31:0];
      funct3_s = 3'($urandom); word_s = 1'($urandom); tag_in_s = 5'($urandom);
      chk("x32_in_ready", 64'(in_ready_s), 64'd1);
      in_valid_s = 1;
      ev = ref_model(funct3_s, word_s, {32'b0, a_s}, {32'b0, b_s}, 32);
      ht = tag_in_s;
      @(posedge clk); #1;
      in_valid_s = 0; a_s = $urandom; b_s = $urandom;
      c = 0;
      while (!out_valid_s && c < 100) begin @(negedge clk); c++; end
      chk("x32_valid", 64'(out_valid_s), 64'd1);
      chk("x32_result", {32'b0, result_s}, {32'b0, ev[31:0]});
      chk("x32_tag", 64'(tag_out_s), 64'(ht));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter XLEN, default 64, SHALL set operand/result width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 5, SHALL set the width of the pass-through tag (destination register index).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that a request is presented.
REQ-006 in_ready  output  1  SHALL indicate that the unit can accept a request.
REQ-007 funct3  input  3  SHALL carry the RV M-extension operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 word  input  1  SHALL select the *W variant (32-bit operate, sign-extend); SHALL be ignored when XLEN=32.
REQ-009 a, b  input  XLEN each  SHALL carry operands rs1 and rs2.
REQ-010 tag_in  input  TAG_W  SHALL carry the request tag.
REQ-011 kill  input  1  SHALL abort any in-flight operation (pipeline flush).
REQ-012 out_valid  output  1  SHALL indicate that result and tag_out are valid.
REQ-013 out_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-014 result  output  XLEN  SHALL carry the operation result.
REQ-015 tag_out  output  TAG_W  SHALL return the tag captured at accept.
REQ-016 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, MUL, DIV, DONE; in_ready SHALL equal (state==IDLE).
REQ-018 Accept SHALL occur on an edge where in_valid & in_ready; funct3, word, a, b, tag_in SHALL be registered at accept and later input changes SHALL have no effect.
REQ-019 On accept, funct3[2]=0 SHALL go to MUL, funct3[2]=1 SHALL go to DIV, except the fast cases in REQ-024/REQ-025, which SHALL go directly to DONE.
REQ-020 MUL SHALL last exactly one cycle then go to DONE; out_valid SHALL first be high 2 cycles after the accept edge.
REQ-021 Multiply SHALL form the full 2*XLEN product with signedness: MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned; MUL returns low XLEN bits, MULH* return high XLEN bits.
REQ-022 DIV SHALL be a restoring radix-2 divider processing one quotient bit per cycle for W cycles (W=32 if word, else XLEN) on operand magnitudes, then go to DONE; out_valid first high W+1 cycles after accept.
REQ-023 Signed results SHALL follow RISC-V: quotient negated when operand signs differ, remainder takes dividend sign; DIVU/REMU unsigned.
REQ-024 Divide by zero SHALL go to DONE in one cycle: quotient all ones, remainder equal to dividend (sign-extended 32-bit dividend when word).
REQ-025 Signed overflow (dividend = most negative, divisor = -1) SHALL go to DONE in one cycle: quotient = dividend, remainder = 0.
REQ-026 When word=1 (XLEN=64), operands SHALL use bits [31:0] only (signed ops sign-interpret bit 31) and result SHALL be the 32-bit result sign-extended to 64 bits, including DIVUW/REMUW.
REQ-027 In DONE, out_valid SHALL be 1 and result/tag_out SHALL hold stable until out_ready; the edge with out_valid & out_ready SHALL return to IDLE.
REQ-028 in_ready SHALL be 0 in DONE; back-to-back issue SHALL occur no earlier than the cycle after the handshake.
REQ-029 kill high on any edge SHALL force IDLE next cycle, drop any pending result (out_valid 0), and block accept on that edge; kill in IDLE SHALL be a no-op.
REQ-030 out_valid SHALL be 0 in IDLE, MUL, DIV.

Reset
REQ-031 reset on any edge SHALL force state IDLE, out_valid 0, in_ready 1, busy 0, result 0, tag_out 0, overriding kill and in_valid.
REQ-032 reset mid-MUL or mid-DIV SHALL discard the operation with no out_valid pulse.

Verification
REQ-033 XLEN=64 MULH a=-1 b=-1 -> result 0 at accept+2; MULHU same -> 0xFFFF_FFFF_FFFF_FFFE; MULHSU a=-1 b=2 -> all ones.
REQ-034 DIV a=-7 b=2 -> out_valid exactly at accept+65, result -3; REM -> -1; DIVUW a=0xFFFF_FFFF b=1 -> 0xFFFF_FFFF_FFFF_FFFF at accept+33.
REQ-035 DIV b=0 a=5 -> result all ones at accept+1; REM -> 5; DIV a=0x8000_0000_0000_0000 b=-1 -> same value, REM -> 0, both at accept+1.
REQ-036 out_ready held low 10 cycles in DONE -> result/tag_out stable, in_ready 0, no second accept; release -> IDLE next cycle.
REQ-037 kill asserted at DIV iteration 20 with in_valid high -> IDLE next cycle, no out_valid, new request accepted the following edge completes correctly.
REQ-038 reset asserted mid-DIV and in DONE -> all outputs at reset values next cycle; random MUL/DIV/*W stream vs reference model, XLEN=32 and 64, random out_ready/kill.
